// File: rtl/prt_vtb_freq_mon.sv
// Frequency stability monitor behind the video toolbox frequency counter: qualifies
// measurements against a tolerance window and reports lock, frequency, no-signal and timeout.
module prt_vtb_freq_mon #(
  parameter logic [31:0] P_SYS_FREQ   = 32'd125000000,
  parameter logic [31:0] P_TOL        = 32'd1000,
  parameter int unsigned P_LOCK_CNT   = 3,
  parameter int unsigned P_UNLOCK_CNT = 2,
  parameter logic [31:0] P_MIN_FREQ   = 32'd1000,
  parameter logic [31:0] P_WDT_CYC    = 2 * P_SYS_FREQ
) (
  input  logic        SYS_RST_IN,
  input  logic        SYS_CLK_IN,
  input  logic        CFG_EN_IN,
  input  logic [31:0] FREQ_IN,
  input  logic        FREQ_UPD_IN,
  output logic        LOCK_OUT,
  output logic [31:0] FREQ_OUT,
  output logic        CHG_OUT,
  output logic        NOSIG_OUT,
  output logic        TMO_OUT
);

  typedef enum logic [1:0] {SM_IDLE, SM_ACQ, SM_LOCK} state_t;

  localparam logic [3:0] LOCK_N   = 4'(P_LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(P_UNLOCK_CNT);

  state_t      state_reg;
  logic [31:0] s_reg;
  logic [31:0] ref_reg;
  logic [31:0] freq_reg;
  logic [31:0] wdt_reg;
  logic [3:0]  match_reg;
  logic [3:0]  miss_reg;
  logic        eval_reg;
  logic        lock_reg;
  logic        chg_reg;
  logic        chg_pend_reg;
  logic        nosig_reg;
  logic        tmo_reg;

  logic [32:0] diff;
  logic        in_win;
  logic        nosig;
  logic        wdt_exp;

  assign diff    = (s_reg >= ref_reg) ? ({1'b0, s_reg} - {1'b0, ref_reg})
                                      : ({1'b0, ref_reg} - {1'b0, s_reg});
  assign in_win  = (diff <= {1'b0, P_TOL});
  assign nosig   = (s_reg < P_MIN_FREQ);
  // Expiry is the 1 -> 0 step of the watchdog; a same-cycle update reloads instead.
  assign wdt_exp = !FREQ_UPD_IN && (wdt_reg == 32'd1);

  // A lock transition arriving while a pulse is still out is deferred one cycle
  // (chg_pend_reg), so CHG_OUT never stays high for two consecutive cycles.
  always_ff @(posedge SYS_CLK_IN or posedge SYS_RST_IN) begin
    if (SYS_RST_IN) begin
      state_reg    <= SM_IDLE;
      s_reg        <= '0;
      ref_reg      <= '0;
      freq_reg     <= '0;
      wdt_reg      <= '0;
      match_reg    <= '0;
      miss_reg     <= '0;
      eval_reg     <= 1'b0;
      lock_reg     <= 1'b0;
      chg_reg      <= 1'b0;
      chg_pend_reg <= 1'b0;
      nosig_reg    <= 1'b0;
      tmo_reg      <= 1'b0;
    end else if (!CFG_EN_IN) begin
      state_reg    <= SM_IDLE;
      s_reg        <= '0;
      ref_reg      <= '0;
      freq_reg     <= '0;
      wdt_reg      <= P_WDT_CYC;
      match_reg    <= '0;
      miss_reg     <= '0;
      eval_reg     <= 1'b0;
      lock_reg     <= 1'b0;
      chg_reg      <= 1'b0;
      chg_pend_reg <= 1'b0;
      nosig_reg    <= 1'b0;
      tmo_reg      <= 1'b0;
    end else begin
      eval_reg     <= 1'b0;
      chg_reg      <= chg_pend_reg & ~chg_reg;
      chg_pend_reg <= chg_pend_reg & chg_reg;

      if (FREQ_UPD_IN) begin
        s_reg    <= FREQ_IN;
        eval_reg <= 1'b1;
        wdt_reg  <= P_WDT_CYC;
        tmo_reg  <= 1'b0;
      end else if (wdt_reg != 32'd0) begin
        wdt_reg <= wdt_reg - 32'd1;
      end

      if (wdt_exp) begin
        tmo_reg   <= 1'b1;
        state_reg <= SM_IDLE;
        match_reg <= '0;
        miss_reg  <= '0;
        if (lock_reg) begin
          lock_reg     <= 1'b0;
          freq_reg     <= '0;
          chg_reg      <= ~chg_reg;
          chg_pend_reg <= chg_reg | chg_pend_reg;
        end
      end else if (eval_reg) begin
        nosig_reg <= nosig;
        case (state_reg)
          SM_IDLE: begin
            if (!nosig) begin
              ref_reg <= s_reg;
              if (LOCK_N == 4'd1) begin
                state_reg    <= SM_LOCK;
                lock_reg     <= 1'b1;
                freq_reg     <= s_reg;
                match_reg    <= '0;
                miss_reg     <= '0;
                chg_reg      <= ~chg_reg;
                chg_pend_reg <= chg_reg | chg_pend_reg;
              end else begin
                state_reg <= SM_ACQ;
                match_reg <= 4'd1;
              end
            end
          end
          SM_ACQ: begin
            if (nosig) begin
              state_reg <= SM_IDLE;
              match_reg <= '0;
            end else if (in_win) begin
              if (match_reg + 4'd1 >= LOCK_N) begin
                state_reg    <= SM_LOCK;
                lock_reg     <= 1'b1;
                freq_reg     <= s_reg;
                ref_reg      <= s_reg;
                match_reg    <= '0;
                miss_reg     <= '0;
                chg_reg      <= ~chg_reg;
                chg_pend_reg <= chg_reg | chg_pend_reg;
              end else begin
                match_reg <= match_reg + 4'd1;
              end
            end else begin
              ref_reg   <= s_reg;
              match_reg <= 4'd1;
            end
          end
          SM_LOCK: begin
            if (in_win && !nosig) begin
              miss_reg <= '0;
              ref_reg  <= s_reg;
              freq_reg <= s_reg;
            end else if (miss_reg + 4'd1 >= UNLOCK_N) begin
              lock_reg     <= 1'b0;
              freq_reg     <= '0;
              miss_reg     <= '0;
              chg_reg      <= ~chg_reg;
              chg_pend_reg <= chg_reg | chg_pend_reg;
              if (nosig) begin
                state_reg <= SM_IDLE;
                match_reg <= '0;
              end else begin
                state_reg <= SM_ACQ;
                ref_reg   <= s_reg;
                match_reg <= 4'd1;
              end
            end else begin
              miss_reg <= miss_reg + 4'd1;
            end
          end
          default: begin
            state_reg <= SM_IDLE;
            match_reg <= '0;
            miss_reg  <= '0;
          end
        endcase
      end
    end
  end

  assign LOCK_OUT  = lock_reg;
  assign FREQ_OUT  = freq_reg;
  assign CHG_OUT   = chg_reg;
  assign NOSIG_OUT = nosig_reg;
  assign TMO_OUT   = tmo_reg;

endmodule

// File: tb/tb_prt_vtb_freq_mon.sv
// Scoreboard bench for prt_vtb_freq_mon: stimulus queues expected status, a monitor
// compares it two clocks after each accepted update or at a scheduled probe cycle.
`timescale 1ns/1ps
module tb_prt_vtb_freq_mon;

  logic        SYS_RST_IN;
  logic        SYS_CLK_IN;
  logic        CFG_EN_IN;
  logic [31:0] FREQ_IN;
  logic        FREQ_UPD_IN;
  logic        LOCK_OUT;
  logic [31:0] FREQ_OUT;
  logic        CHG_OUT;
  logic        NOSIG_OUT;
  logic        TMO_OUT;

  prt_vtb_freq_mon #(
    .P_WDT_CYC (32'd1000)
  ) dut (
    .SYS_RST_IN  (SYS_RST_IN),
    .SYS_CLK_IN  (SYS_CLK_IN),
    .CFG_EN_IN   (CFG_EN_IN),
    .FREQ_IN     (FREQ_IN),
    .FREQ_UPD_IN (FREQ_UPD_IN),
    .LOCK_OUT    (LOCK_OUT),
    .FREQ_OUT    (FREQ_OUT),
    .CHG_OUT     (CHG_OUT),
    .NOSIG_OUT   (NOSIG_OUT),
    .TMO_OUT     (TMO_OUT)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        lock;
    logic [31:0] freq;
    logic        nosig;
    logic        tmo;
    logic        chg;
    logic [95:0] name;
  } exp_t;

  exp_t        rsp_q[$];
  exp_t        prb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cyc = '0;
  logic [31:0] last_cap = '0;
  int          chg_seen = 0;
  int          chg_exp = 0;
  int          chg_consec = 0;
  logic        chg_prev = 1'b0;
  logic        acc_d1 = 1'b0;
  logic        acc_d2 = 1'b0;
  logic        done_req = 1'b0;
  logic        done_ack = 1'b0;

  initial SYS_CLK_IN = 1'b0;
  always #5 SYS_CLK_IN = ~SYS_CLK_IN;

  always @(posedge SYS_CLK_IN) cyc <= cyc + 32'd1;

  // Accepted updates, delayed to the cycle their status becomes visible.
  always @(posedge SYS_CLK_IN or posedge SYS_RST_IN) begin
    if (SYS_RST_IN) begin
      acc_d1 <= 1'b0;
      acc_d2 <= 1'b0;
    end else begin
      acc_d1 <= FREQ_UPD_IN & CFG_EN_IN;
      acc_d2 <= acc_d1;
    end
  end

  task automatic check(input exp_t e);
    n_cmp++;
    if (LOCK_OUT !== e.lock || FREQ_OUT !== e.freq || NOSIG_OUT !== e.nosig ||
        TMO_OUT !== e.tmo || CHG_OUT !== e.chg) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got lock=%b freq=%0d nosig=%b tmo=%b chg=%b, want lock=%b freq=%0d nosig=%b tmo=%b chg=%b",
               e.name, cyc, LOCK_OUT, FREQ_OUT, NOSIG_OUT, TMO_OUT, CHG_OUT,
               e.lock, e.freq, e.nosig, e.tmo, e.chg);
    end else begin
      $display("ok   %s cyc=%0d: lock=%b freq=%0d nosig=%b tmo=%b chg=%b",
               e.name, cyc, LOCK_OUT, FREQ_OUT, NOSIG_OUT, TMO_OUT, CHG_OUT);
    end
  endtask

  always @(negedge SYS_CLK_IN) begin
    if (CHG_OUT) begin
      chg_seen++;
      if (chg_prev) chg_consec++;
    end
    chg_prev = CHG_OUT;
    if (acc_d2) begin
      if (rsp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp cyc=%0d: got lock=%b freq=%0d, want no pending response",
                 cyc, LOCK_OUT, FREQ_OUT);
      end else begin
        check(rsp_q.pop_front());
      end
    end
    while (prb_q.size() != 0 && prb_q[0].cyc == cyc) check(prb_q.pop_front());
    if (done_req && !done_ack) begin
      n_cmp++;
      if (rsp_q.size() != 0 || prb_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain: got %0d rsp / %0d probe left, want 0 / 0", rsp_q.size(), prb_q.size());
      end
      n_cmp++;
      if (chg_seen != chg_exp) begin
        n_bad++;
        $display("FAIL chg_count: got %0d pulses, want %0d", chg_seen, chg_exp);
      end else begin
        $display("ok   chg_count: %0d pulses", chg_seen);
      end
      n_cmp++;
      if (chg_consec != 0) begin
        n_bad++;
        $display("FAIL chg_consec: got %0d back-to-back pulses, want 0", chg_consec);
      end
      done_ack = 1'b1;
    end
  end

  task automatic strobe(input logic [31:0] f, input logic l, input logic [31:0] fo,
                        input logic ns, input logic tm, input logic ch, input logic [95:0] nm);
    exp_t e;
    e.cyc = '0; e.lock = l; e.freq = fo; e.nosig = ns; e.tmo = tm; e.chg = ch; e.name = nm;
    rsp_q.push_back(e);
    if (ch) chg_exp++;
    FREQ_IN     = f;
    FREQ_UPD_IN = 1'b1;
    @(posedge SYS_CLK_IN);
    #1 last_cap = cyc;
    @(negedge SYS_CLK_IN);
    FREQ_UPD_IN = 1'b0;
    repeat (3) @(negedge SYS_CLK_IN);
  endtask

  task automatic probe(input logic [31:0] at, input logic l, input logic [31:0] fo,
                       input logic ns, input logic tm, input logic ch, input logic [95:0] nm);
    exp_t e;
    e.cyc = at; e.lock = l; e.freq = fo; e.nosig = ns; e.tmo = tm; e.chg = ch; e.name = nm;
    prb_q.push_back(e);
    if (ch) chg_exp++;
  endtask

  task automatic en_clear(input logic [95:0] nm);
    probe(cyc + 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, nm);
    CFG_EN_IN = 1'b0;
    @(negedge SYS_CLK_IN);
    CFG_EN_IN = 1'b1;
    @(negedge SYS_CLK_IN);
  endtask

  initial begin
    #200us;
    $display("FAIL global_timeout: got no finish, want finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c0;
    SYS_RST_IN  = 1'b1;
    CFG_EN_IN   = 1'b1;
    FREQ_IN     = '0;
    FREQ_UPD_IN = 1'b0;
    @(negedge SYS_CLK_IN);
    probe(cyc + 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "reset");
    @(negedge SYS_CLK_IN);
    @(negedge SYS_CLK_IN);
    SYS_RST_IN = 1'b0;
    @(negedge SYS_CLK_IN);

    // Default acquisition: lock on the third sample.
    strobe(32'd148500000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t1_s1");
    strobe(32'd148500400, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t1_s2");
    strobe(32'd148499700, 1'b1, 32'd148499700, 1'b0, 1'b0, 1'b1, "t1_lock");

    // Tolerance edge: exactly P_TOL stays in, P_TOL+1 counts as a miss.
    en_clear("t2_en_clr");
    strobe(32'd74250000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t2_s1");
    strobe(32'd74250000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t2_s2");
    strobe(32'd74250000, 1'b1, 32'd74250000, 1'b0, 1'b0, 1'b1, "t2_lock");
    strobe(32'd74251000, 1'b1, 32'd74251000, 1'b0, 1'b0, 1'b0, "t2_tol_in");
    strobe(32'd74252001, 1'b1, 32'd74251000, 1'b0, 1'b0, 1'b0, "t2_miss1");
    strobe(32'd74252001, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "t2_unlock");

    // Reacquire, then a single miss that a good sample clears.
    strobe(32'd27000000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t3_ref");
    strobe(32'd27000500, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t3_s2");
    strobe(32'd27000500, 1'b1, 32'd27000500, 1'b0, 1'b0, 1'b1, "t3_lock");
    strobe(32'd30000000, 1'b1, 32'd27000500, 1'b0, 1'b0, 1'b0, "t3_miss");
    strobe(32'd27000600, 1'b1, 32'd27000600, 1'b0, 1'b0, 1'b0, "t3_good");
    strobe(32'd30000000, 1'b1, 32'd27000600, 1'b0, 1'b0, 1'b0, "t3_miss_b");
    strobe(32'd27000600, 1'b1, 32'd27000600, 1'b0, 1'b0, 1'b0, "t3_good_b");

    // No signal: two zero samples drop lock into idle.
    strobe(32'd0, 1'b1, 32'd27000600, 1'b1, 1'b0, 1'b0, "t4_nosig1");
    strobe(32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, "t4_nosig2");
    strobe(32'd500, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, "t4_idle");

    // Watchdog expiry exactly 1000 cycles after the last capture.
    strobe(32'd50000000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t5_s1");
    strobe(32'd50000000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t5_s2");
    strobe(32'd50000000, 1'b1, 32'd50000000, 1'b0, 1'b0, 1'b1, "t5_lock");
    c0 = last_cap;
    probe(c0 + 32'd999,  1'b1, 32'd50000000, 1'b0, 1'b0, 1'b0, "t5_pre_exp");
    probe(c0 + 32'd1000, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, "t5_expire");
    probe(c0 + 32'd1001, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, "t5_sticky");
    while (cyc < c0 + 32'd1002) @(negedge SYS_CLK_IN);
    strobe(32'd50000000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t5_tmo_clr");
    strobe(32'd50000000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t5_r2");
    strobe(32'd50000000, 1'b1, 32'd50000000, 1'b0, 1'b0, 1'b1, "t5_relock");
    c0 = last_cap;
    while (cyc < c0 + 32'd999) @(negedge SYS_CLK_IN);
    probe(c0 + 32'd1000, 1'b1, 32'd50000000, 1'b0, 1'b0, 1'b0, "t5_no_exp");
    strobe(32'd50000000, 1'b1, 32'd50000000, 1'b0, 1'b0, 1'b0, "t5_edge_rsp");

    // Enable drop while locked and mid-acquisition, then async reset while locked.
    en_clear("t6_clr_lock");
    strobe(32'd60000000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t6_pre1");
    strobe(32'd60000000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t6_pre2");
    en_clear("t6_clr_acq");
    strobe(32'd60000000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t6_new1");
    strobe(32'd60000000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t6_new2");
    strobe(32'd60000000, 1'b1, 32'd60000000, 1'b0, 1'b0, 1'b1, "t6_lock");
    probe(cyc + 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t6_rst_async");
    probe(cyc + 32'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, "t6_rst_hold");
    @(posedge SYS_CLK_IN);
    #2 SYS_RST_IN = 1'b1;
    @(negedge SYS_CLK_IN);
    @(negedge SYS_CLK_IN);
    @(negedge SYS_CLK_IN);
    SYS_RST_IN = 1'b0;
    repeat (4) @(negedge SYS_CLK_IN);

    done_req = 1'b1;
    repeat (10) begin
      if (!done_ack) @(negedge SYS_CLK_IN);
    end
    #1;
    if (!done_ack) begin
      $display("FAIL final_checks: got no monitor response, want final checks done");
      $fatal(1, "monitor stalled");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
